// File: rtl/subleq_ctrl_if.sv
// Memory-port and ALU signals between the Subleq sequencer (master) and its
// synchronous single-port memory plus combinational ALU (slave).
interface subleq_ctrl_if #(
   parameter int P_DATA = 8,
   parameter int P_ADDR = 8
);
   logic [P_ADDR-1:0] mem_addr;
   logic [P_DATA-1:0] mem_rdata;
   logic [P_DATA-1:0] mem_wdata;
   logic              mem_we;
   logic [P_DATA-1:0] alu_a;
   logic [P_DATA-1:0] alu_b;
   logic [P_DATA-1:0] alu_r;
   logic              alu_z;

   modport master (
      output mem_addr, mem_wdata, mem_we, alu_a, alu_b,
      input  mem_rdata, alu_r, alu_z
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, alu_a, alu_b,
      output mem_rdata, alu_r, alu_z
   );
endinterface

// File: rtl/subleq_ctrl.sv
// Subleq instruction sequencer: fetch A,B,C, read mem[A]/mem[B], write mem[B]-mem[A], branch.
// Optional macro SUBLEQ_INSTRET_EN adds a 32-bit retired-instruction counter output.
module subleq_ctrl #(
   parameter int P_DATA = 8,
   parameter int P_ADDR = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   subleq_ctrl_if.master     bus,
   output logic [P_ADDR-1:0] pc,
   output logic              halt
`ifdef SUBLEQ_INSTRET_EN
   ,
   output logic [31:0]       instret
`endif
);

   localparam logic [2:0] S_FA   = 3'd0;
   localparam logic [2:0] S_FB   = 3'd1;
   localparam logic [2:0] S_FC   = 3'd2;
   localparam logic [2:0] S_RA   = 3'd3;
   localparam logic [2:0] S_RB   = 3'd4;
   localparam logic [2:0] S_EX   = 3'd5;
   localparam logic [2:0] S_WB   = 3'd6;
   localparam logic [2:0] S_HALT = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [P_ADDR-1:0] pc_q, pc_d;
   logic [P_DATA-1:0] ra_q, ra_d;
   logic [P_DATA-1:0] rb_q, rb_d;
   logic [P_DATA-1:0] rc_q, rc_d;
   logic [P_DATA-1:0] opa_q, opa_d;
   logic [P_DATA-1:0] opb_q, opb_d;
   logic              halt_q, halt_d;
`ifdef SUBLEQ_INSTRET_EN
   logic [31:0]       instret_q, instret_d;
`endif

   // Each fetch state captures the word addressed in the previous cycle.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      halt_d  = halt_q;
      case (state_q)
         S_FA: if (run) state_d = S_FB;
         S_FB: begin ra_d  = bus.mem_rdata; state_d = S_FC; end
         S_FC: begin rb_d  = bus.mem_rdata; state_d = S_RA; end
         S_RA: begin rc_d  = bus.mem_rdata; state_d = S_RB; end
         S_RB: begin opa_d = bus.mem_rdata; state_d = S_EX; end
         S_EX: begin opb_d = bus.mem_rdata; state_d = S_WB; end
         S_WB: begin
            pc_d = bus.alu_z ? rc_q[P_ADDR-1:0] : pc_q + P_ADDR'(3);
            if (bus.alu_z && (&rc_q)) begin
               state_d = S_HALT;
               halt_d  = 1'b1;
            end else begin
               state_d = S_FA;
            end
         end
         default: ;
      endcase
   end

`ifdef SUBLEQ_INSTRET_EN
   always_comb begin
      instret_d = instret_q;
      if (state_q == S_WB) instret_d = instret_q + 32'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FA;
         pc_q      <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         rc_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         halt_q    <= 1'b0;
`ifdef SUBLEQ_INSTRET_EN
         instret_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         rc_q      <= rc_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         halt_q    <= halt_d;
`ifdef SUBLEQ_INSTRET_EN
         instret_q <= instret_d;
`endif
      end
   end

   // Write enable is gated by rst so a reset landing in WB never corrupts memory.
   always_comb begin
      bus.mem_addr  = pc_q;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      case (state_q)
         S_FB:       bus.mem_addr = pc_q + P_ADDR'(1);
         S_FC:       bus.mem_addr = pc_q + P_ADDR'(2);
         S_RA:       bus.mem_addr = ra_q[P_ADDR-1:0];
         S_RB, S_EX: bus.mem_addr = rb_q[P_ADDR-1:0];
         S_WB: begin
            bus.mem_addr  = rb_q[P_ADDR-1:0];
            bus.mem_we    = ~rst;
            bus.mem_wdata = bus.alu_r;
         end
         default: ;
      endcase
   end

   assign bus.alu_a = opb_q;
   assign bus.alu_b = opa_q;
   assign pc        = pc_q;
   assign halt      = halt_q;
`ifdef SUBLEQ_INSTRET_EN
   assign instret   = instret_q;
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// Scoreboard bench for subleq_ctrl: expected writes are queued by the stimulus,
// a negedge monitor pops them on every mem_we and checks address, data and next pc.
module tb_subleq_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [7:0] pc;
   logic       halt;
`ifdef SUBLEQ_INSTRET_EN
   logic [31:0] instret;
`endif

   subleq_ctrl_if #(.P_DATA(8), .P_ADDR(8)) bus ();

   subleq_ctrl #(.P_DATA(8), .P_ADDR(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .bus  (bus),
      .pc   (pc),
      .halt (halt)
`ifdef SUBLEQ_INSTRET_EN
      ,
      .instret (instret)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   logic       ld_en   = 1'b0;
   logic [7:0] ld_addr = 8'h00;
   logic [7:0] ld_data = 8'h00;

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   assign bus.alu_r = bus.alu_a - bus.alu_b;
   assign bus.alu_z = ($signed(bus.alu_r) <= 8'sd0);

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] pc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] a, input logic [7:0] d, input logic [7:0] p);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.pc   = p;
      return e;
   endfunction

   initial begin : monitor
      exp_t       e;
      logic       pend;
      logic [7:0] epc;
      pend = 1'b0;
      epc  = 8'h00;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("pc_after_wb", pc, epc);
            pend = 1'b0;
         end
         if (bus.mem_we) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                        bus.mem_addr, bus.mem_wdata);
            end else begin
               e = q.pop_front();
               chk("wr_addr", bus.mem_addr, e.addr);
               chk("wr_data", bus.mem_wdata, e.data);
               pend = 1'b1;
               epc  = e.pc;
            end
         end
      end
   end

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic reset_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] va, input logic [7:0] vb);
      rst = 1'b1;
      run = 1'b0;
      load(8'd0, a);
      load(8'd1, b);
      load(8'd2, c);
      load(8'd16, va);
      load(8'd17, vb);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One-cycle run pulse; WB must be the 7th cycle, then FA at the expected pc.
   task automatic run_instr(input logic [7:0] exp_pc);
      @(negedge clk);
      run = 1'b1;
      @(posedge clk);
      #1 run = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("we_in_7th_cycle", bus.mem_we, 1);
      @(posedge clk);
      #1 chk("addr_after_wb", bus.mem_addr, exp_pc);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // Reset landing in WB with run held high must not write.
      reset_load(8'd16, 8'd17, 8'd9, 8'd3, 8'd10);
      @(negedge clk);
      run = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_in_wb_we", bus.mem_we, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      #1;
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_pc", pc, 0);
      chk("rst_halt", halt, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_no_write", mem[17], 8'd10);

      // run gating, then a no-branch instruction from a single-cycle run pulse.
      reset_load(8'd16, 8'd17, 8'd9, 8'd3, 8'd10);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_addr", bus.mem_addr, 0);
      end
      q.push_back(mk(8'd17, 8'd7, 8'd3));
      run_instr(8'd3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_after_addr", bus.mem_addr, 3);
      end
      chk("nobranch_pc", pc, 3);
      chk("nobranch_mem", mem[17], 8'd7);

      // Branch on zero.
      reset_load(8'd16, 8'd17, 8'd9, 8'd10, 8'd10);
      q.push_back(mk(8'd17, 8'd0, 8'd9));
      run_instr(8'd9);

      // Branch on negative.
      reset_load(8'd16, 8'd17, 8'd9, 8'd5, 8'd2);
      q.push_back(mk(8'd17, 8'hFD, 8'd9));
      run_instr(8'd9);

      // Signed wrap: 0x80 - 1 = 0x7F is positive, so no branch.
      reset_load(8'd16, 8'd17, 8'd9, 8'h01, 8'h80);
      q.push_back(mk(8'd17, 8'h7F, 8'd3));
      run_instr(8'd3);

      // Halt on branch to all-ones.
      reset_load(8'd16, 8'd17, 8'hFF, 8'd4, 8'd4);
      q.push_back(mk(8'd17, 8'd0, 8'hFF));
      run_instr(8'hFF);
      run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_sticky", halt, 1);
      end
      run = 1'b0;
      chk("halt_pc", pc, 8'hFF);
`ifdef SUBLEQ_INSTRET_EN
      chk("instret_halt", instret, 32'd1);
`endif

      // Branch to 0xFD, then a non-branching instruction there wraps pc to 0.
      reset_load(8'd16, 8'd17, 8'hFD, 8'd5, 8'd5);
      load(8'hFD, 8'd20);
      load(8'hFE, 8'd21);
      load(8'hFF, 8'h40);
      load(8'd20, 8'd1);
      load(8'd21, 8'd5);
      q.push_back(mk(8'd17, 8'd0, 8'hFD));
      run_instr(8'hFD);
      q.push_back(mk(8'd21, 8'd4, 8'h00));
      run_instr(8'h00);
      chk("wrap_mem", mem[21], 8'd4);
`ifdef SUBLEQ_INSTRET_EN
      chk("instret_two", instret, 32'd2);
`endif

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
